// File: rtl/dmem_access_arbiter_pkg.sv
// Shared constants and FSM encoding for the data-memory access arbiter.
package dmem_access_arbiter_pkg;

    localparam int unsigned DMEM_WIDTH = 32;
    localparam int unsigned DMEM_DEPTH = 100;

    typedef enum logic {
        StArb    = 1'b0,
        StLocked = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module dmem_access_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IW    = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    int unsigned    j;
    logic [IW-1:0]  jj;
    logic           found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j  = (32'(ptr_i) + k) % N_REQ;
            jj = IW'(j);
            if (req_i[jj] && !found) begin
                found     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing one single-port data memory, with burst lock.
module dmem_access_arbiter
    import dmem_access_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned AW    = DMEM_WIDTH,
    parameter int unsigned DEPTH = DMEM_DEPTH
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    we_i,
    input  logic [N_REQ-1:0]    lock_i,
    input  logic [N_REQ*AW-1:0] addr_i,
    input  logic [N_REQ*AW-1:0] wdata_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    rvalid_o,
    output logic [AW-1:0]       rdata_o,
    output logic [N_REQ-1:0]    err_o,
    output logic [AW-1:0]       mem_a_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_wd_o,
    input  logic [AW-1:0]       mem_rd_i
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, owner_q, owner_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d, err_q, err_d;
    logic [AW-1:0]     rdata_q, rdata_d;

    logic              owner_hold, any_gnt, in_range, g_we, g_lock;
    logic [N_REQ-1:0]  pick_req, pick_gnt;
    logic [IW-1:0]     g_idx;
    logic [AW-1:0]     g_addr, g_wdata;

    // A locked owner that still requests masks everyone else; otherwise arbitrate normally.
    assign owner_hold = (state_q == StLocked) && req_i[owner_q];
    assign pick_req   = owner_hold ? (N_REQ'(1) << owner_q) : req_i;

    dmem_access_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (g_idx)
    );

    assign gnt_o    = RST ? pick_gnt : '0;
    assign any_gnt  = |gnt_o;
    assign g_addr   = addr_i[g_idx*AW +: AW];
    assign g_wdata  = wdata_i[g_idx*AW +: AW];
    assign g_we     = we_i[g_idx];
    assign g_lock   = lock_i[g_idx];
    assign in_range = g_addr < AW'(DEPTH);

    assign mem_a_o  = any_gnt ? g_addr : '0;
    assign mem_wd_o = any_gnt ? g_wdata : '0;
    assign mem_we_o = any_gnt & g_we & in_range;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        if (any_gnt) begin
            if (owner_hold) begin
                if (!g_lock) state_d = StArb;
            end else begin
                ptr_d   = (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
                owner_d = g_idx;
                state_d = g_lock ? StLocked : StArb;
            end
            if (!g_we) begin
                rvalid_d = gnt_o;
                rdata_d  = in_range ? mem_rd_i : '0;
            end
            if (!in_range) err_d = gnt_o;
        end else begin
            state_d = StArb;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StArb;
            ptr_q    <= '0;
            owner_q  <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule
